// File: rtl/cbx_ccff_loader.sv
// cbx_ccff_loader: serializes bitstream words onto a tile configuration chain
module cbx_ccff_loader #(
   parameter int CHAIN_LEN = 11,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              tail_parity
);
   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WORD_W + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state;
   logic [BW-1:0]     bits_left;
   logic [WW-1:0]     word_left;
   logic [WORD_W-1:0] sreg;

   // abort suppresses the accept, the shift and the done pulse in its own cycle
   always_comb begin
      busy          = state != IDLE;
      bs_ready      = state == FETCH && !abort;
      ccff_shift_en = state == SHIFT && !abort;
      ccff_head     = ccff_shift_en & sreg[WORD_W-1];
      done          = state == DONE && !abort;
   end

   // load sequencing: fetch a word, shift it MSB first, refetch until the chain is full
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state       <= IDLE;
         bits_left   <= '0;
         word_left   <= '0;
         sreg        <= '0;
         err         <= 1'b0;
         tail_parity <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            bits_left   <= BW'(CHAIN_LEN);
            tail_parity <= 1'b0;
            err         <= 1'b0;
            state       <= FETCH;
         end
      end else if (abort) begin
         state <= IDLE;
         err   <= 1'b1;
      end else begin
         case (state)
            FETCH: if (bs_valid) begin
               sreg      <= bs_data;
               word_left <= WW'(WORD_W);
               state     <= SHIFT;
            end
            SHIFT: begin
               sreg        <= sreg << 1;
               tail_parity <= tail_parity ^ ccff_tail;
               bits_left   <= bits_left - 1'b1;
               word_left   <= word_left - 1'b1;
               state       <= bits_left == BW'(1) ? DONE : word_left == WW'(1) ? FETCH : SHIFT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cbx_ccff_loader.sv
// tb_cbx_ccff_loader: scoreboard bench for the configuration chain loader
module tb_cbx_ccff_loader;
   logic prog_clk = 1'b0;
   logic pReset, start, abort, bs_valid, ccff_tail;
   logic [7:0] bs_data;
   logic bs_ready, ccff_head, ccff_shift_en, busy, done, err, tail_parity;
   logic s8, v8, t8;
   logic [7:0] d8;
   logic r8, h8, e8, b8, dn8, er8, p8;

   always #5 prog_clk = ~prog_clk;

   cbx_ccff_loader dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .err(err), .tail_parity(tail_parity)
   );

   cbx_ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u8 (
      .prog_clk(prog_clk), .pReset(pReset), .start(s8), .abort(1'b0),
      .bs_data(d8), .bs_valid(v8), .bs_ready(r8),
      .ccff_head(h8), .ccff_shift_en(e8), .ccff_tail(t8),
      .busy(b8), .done(dn8), .err(er8), .tail_parity(p8)
   );

   typedef struct {int cyc; logic par;} done_t;

   int tests = 0, fails = 0, cyc = 0;
   int shifts = 0, rdys = 0, dones = 0;
   int gap_next = 0, hold = 0;
   logic hq[$];
   done_t dq[$];
   logic [7:0] wq[$];
   logic [10:0] chain = '0;
   logic tk;

   // cycle index and a behavioural model of the 11-bit scan chain
   always @(posedge prog_clk) begin
      cyc <= cyc + 1;
      if (ccff_shift_en) chain <= {chain[9:0], ccff_head};
   end
   assign ccff_tail = chain[10];
   assign t8 = 1'b0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic fail(input string n);
      tests++;
      fails++;
      $display("FAIL %s: event with nothing expected", n);
   endtask

   // monitor: pops expected head bits and done records as the DUT presents them
   always @(negedge prog_clk) begin
      done_t d;
      if (ccff_shift_en) begin
         shifts++;
         if (hq.size() == 0) fail("extra_shift");
         else chk("head", ccff_head, hq.pop_front());
      end else chk("head_gated", ccff_head, 1'b0);
      if (bs_ready) rdys++;
      if (done) begin
         dones++;
         if (dq.size() == 0) fail("unexpected_done");
         else begin
            d = dq.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("parity", tail_parity, d.par);
         end
      end
   end

   // word feeder: holds bs_valid high while words are queued, with an optional gap before word 1
   initial begin
      bs_valid = 1'b0;
      bs_data  = '0;
      forever begin
         @(negedge prog_clk);
         tk = bs_valid && bs_ready;
         if (bs_ready && !bs_valid && hold > 0) hold--;
         @(posedge prog_clk);
         #1;
         if (tk && wq.size() > 0) begin
            void'(wq.pop_front());
            hold = gap_next;
            gap_next = 0;
         end
         bs_valid = wq.size() > 0 && hold == 0;
         bs_data  = wq.size() > 0 ? wq[0] : 8'h00;
      end
   end

   task automatic start_load(input logic [7:0] w0, input logic [7:0] w1, input int gap);
      logic [15:0] p;
      p = {w0, w1};
      for (int i = 0; i < 11; i++) hq.push_back(p[15-i]);
      dq.push_back('{cyc + 14 + gap, ^chain});
      wq.push_back(w0);
      wq.push_back(w1);
      gap_next = gap;
      start = 1'b1;
      @(posedge prog_clk) #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      d0 = dones;
      for (int i = 0; i < 60; i++) begin
         @(posedge prog_clk) #1;
         if (dones != d0) return;
      end
      fail("done_timeout");
   endtask

   task automatic flush();
      hq.delete();
      dq.delete();
      wq.delete();
      gap_next = 0;
      hold = 0;
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_busy"}, busy, 1'b0);
      chk({n, "_done"}, done, 1'b0);
      chk({n, "_ready"}, bs_ready, 1'b0);
      chk({n, "_shift"}, ccff_shift_en, 1'b0);
      chk({n, "_head"}, ccff_head, 1'b0);
      chk({n, "_err"}, err, 1'b0);
      chk({n, "_par"}, tail_parity, 1'b0);
   endtask

   initial begin
      int d0, nr, ns, dc, c0;
      logic [7:0] bits;
      pReset = 1'b1; start = 1'b0; abort = 1'b0;
      s8 = 1'b0; v8 = 1'b0; d8 = '0;
      repeat (3) @(posedge prog_clk) #1;
      chk_zero("reset");
      pReset = 1'b0;

      rdys = 0; shifts = 0;
      start_load(8'hA5, 8'hE0, 0);
      wait_done();
      chk("ready_cycles", rdys, 2);
      chk("shift_count", shifts, 11);
      chk("idle_after_done", busy, 1'b0);
      chk("parity_first", tail_parity, 1'b0);

      start_load(8'hA5, 8'hE0, 0);
      wait_done();
      repeat (2) @(posedge prog_clk) #1;
      chk("parity_hold", tail_parity, 1'b1);

      shifts = 0;
      start_load(8'hA5, 8'hE0, 5);
      wait_done();
      chk("gap_shift_count", shifts, 11);

      shifts = 0;
      d0 = dones;
      start_load(8'h5A, 8'h1F, 0);
      for (int i = 0; i < 40 && shifts < 4; i++) @(posedge prog_clk) #1;
      abort = 1'b1;
      @(posedge prog_clk) #1;
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_err", err, 1'b1);
      chk("abort_shifts", shifts, 4);
      flush();
      repeat (6) @(posedge prog_clk) #1;
      chk("abort_no_done", dones, d0);
      start_load(8'hA5, 8'hE0, 0);
      chk("err_cleared", err, 1'b0);
      chk("busy_after_start", busy, 1'b1);
      wait_done();

      shifts = 0;
      start_load(8'hC3, 8'h60, 0);
      repeat (3) @(posedge prog_clk) #1;
      start = 1'b1;
      @(posedge prog_clk) #1 start = 1'b0;
      wait_done();
      chk("start_in_shift", shifts, 11);

      start_load(8'hFF, 8'hFF, 0);
      repeat (5) @(posedge prog_clk) #1;
      pReset = 1'b1; start = 1'b1; abort = 1'b1;
      @(posedge prog_clk) #1;
      chk_zero("midreset");
      pReset = 1'b0; start = 1'b0; abort = 1'b0;
      flush();
      @(posedge prog_clk) #1;
      chk("midreset_idle", busy, 1'b0);
      start_load(8'hA5, 8'hE0, 0);
      wait_done();

      nr = 0; ns = 0; dc = 0; bits = '0;
      s8 = 1'b1; v8 = 1'b1; d8 = 8'h3C;
      c0 = cyc;
      @(posedge prog_clk) #1 s8 = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (r8) nr++;
         if (e8) begin
            bits = {bits[6:0], h8};
            ns++;
         end
         if (dn8) dc = cyc - c0;
         @(posedge prog_clk) #1;
      end
      v8 = 1'b0;
      chk("c8_fetches", nr, 1);
      chk("c8_shifts", ns, 8);
      chk("c8_bits", bits, 8'h3C);
      chk("c8_done_cycle", dc, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
